// File: rtl/if_id_queue_pkg.sv
// Shared RV32 front-end defines and the IF->ID queue operation type.
// Macros are guarded so an existing shared defines file takes precedence.
`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif
`ifndef RV32_INST_WIDTH
`define RV32_INST_WIDTH 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef RST_INST_ADDR
`define RST_INST_ADDR 32'h8000_0000
`endif
`ifndef FLUSH_ENABLE
`define FLUSH_ENABLE 1'b1
`endif
`ifndef FLUSH_DISABLE
`define FLUSH_DISABLE 1'b0
`endif
`ifndef IF_ID_QUEUE_DEPTH
`define IF_ID_QUEUE_DEPTH 2
`endif

package if_id_queue_pkg;

    typedef enum logic [1:0] {
        Q_IDLE     = 2'b00,
        Q_POP      = 2'b01,
        Q_PUSH     = 2'b10,
        Q_PUSH_POP = 2'b11
    } q_op_e;

    function automatic q_op_e decode_op(input logic push, input logic pop);
        return q_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port, no reset on the storage.
module if_id_queue_mem #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID circular queue with valid/ready on both sides, flush and stall.
// Optional same-cycle bypass when empty: define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned               ADDR_WIDTH = `RV32_ADDR_WIDTH,
    parameter int unsigned               INST_WIDTH = `RV32_INST_WIDTH,
    parameter int unsigned               DEPTH      = `IF_ID_QUEUE_DEPTH,
    parameter logic [ADDR_WIDTH-1:0]     RST_ADDR   = `RST_INST_ADDR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipeline_flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ADDR_WIDTH-1:0]    inst_addr_i,
    input  logic [INST_WIDTH-1:0]    inst_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDR_WIDTH-1:0]    inst_addr_o,
    output logic [INST_WIDTH-1:0]    inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = ADDR_WIDTH + INST_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          empty, full, bypass, push, pop;
    logic [EW-1:0] rd_data;
    q_op_e         op;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid_i && !pipeline_flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready_o  = !full && !pipeline_flush_i;
    assign out_valid_o = (!empty && !pipeline_flush_i) || bypass;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign push = in_valid_i && in_ready_o && !(bypass && out_ready_i);
    assign pop  = out_valid_o && out_ready_i && !empty;
    assign op   = decode_op(push, pop);

    always_comb begin
        inst_addr_o = RST_ADDR;
        inst_o      = INST_WIDTH'(`INST_NOP);
        if (bypass) begin
            inst_addr_o = inst_addr_i;
            inst_o      = inst_i;
        end else if (out_valid_o) begin
            inst_addr_o = rd_data[EW-1:INST_WIDTH];
            inst_o      = rd_data[INST_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (pipeline_flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            case (op)
                Q_PUSH: begin
                    wptr  <= wptr + AW'(1);
                    count <= count + CW'(1);
                end
                Q_POP: begin
                    rptr  <= rptr + AW'(1);
                    count <= count - CW'(1);
                end
                Q_PUSH_POP: begin
                    wptr <= wptr + AW'(1);
                    rptr <= rptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign count_o = count;

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata ({inst_addr_i, inst_i}),
        .raddr (rptr),
        .rdata (rd_data)
    );

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-stage IF->ID buffer. Sits between the fetch unit and the decoder.
- Holds up to DEPTH fetched {address, instruction} pairs in a circular queue with valid/ready handshakes on both sides.
- Supports pipeline flush and back-pressure (decoder stall).
- Presents NOP and the reset address whenever no valid entry is available.

Parameters:
- ADDR_WIDTH, `RV32_ADDR_WIDTH (32): instruction address width.
- INST_WIDTH, `RV32_INST_WIDTH (32): instruction width.
- DEPTH, 2: number of queue entries; power of two, at least 2.
- RST_ADDR, `RST_INST_ADDR: address driven when the output is not valid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pipeline_flush_i  input  1  synchronous flush; drops all held entries.
- in_valid_i  input  1  fetch presents a valid instruction.
- in_ready_o  output  1  queue can accept an entry this cycle.
- inst_addr_i  input  ADDR_WIDTH  fetched instruction address.
- inst_i  input  INST_WIDTH  fetched instruction.
- out_valid_o  output  1  head entry valid for decode.
- out_ready_i  input  1  decoder consumes the head entry this cycle.
- inst_addr_o  output  ADDR_WIDTH  head entry address, or RST_ADDR when not valid.
- inst_o  output  INST_WIDTH  head entry instruction, or `INST_NOP when not valid.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries (registered).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wptr=0, rptr=0, count=0.
  - out_valid_o=0, inst_o=`INST_NOP, inst_addr_o=RST_ADDR, in_ready_o=1 after release, count_o=0.
  - Entry storage is not reset.
- Push occurs when in_valid_i && in_ready_o && !pipeline_flush_i.
  - Writes {inst_addr_i, inst_i} at wptr.
  - wptr increments modulo DEPTH; wrap is natural because DEPTH is a power of two.
- Pop occurs when out_valid_o && out_ready_i.
  - rptr increments modulo DEPTH.
- in_ready_o = (count != DEPTH) && !pipeline_flush_i.
  - Depends only on registered state and the flush input; no combinational path from out_ready_i.
- out_valid_o = (count != 0) && !pipeline_flush_i.
- inst_o / inst_addr_o:
  - When out_valid_o=1: mem[rptr].
  - Otherwise: `INST_NOP / RST_ADDR.
- Count update per edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged.
  - count never exceeds DEPTH and never underflows; push when full is impossible by construction.
- Latency: an entry pushed at edge N is visible on the outputs after edge N, i.e. 1 cycle, when the queue was empty.
- Throughput: 1 entry/cycle sustained while out_ready_i=1.
- Flush (pipeline_flush_i=1 at edge N):
  - Outputs are forced to NOP/RST_ADDR and not-valid during the flush cycle itself (combinational).
  - At edge N, wptr=rptr=0 and count=0. Any same-cycle push or pop is ignored.
  - Flush held for several cycles keeps the queue empty.
  - The first push is accepted in the cycle after flush deasserts.
- Flush has priority over push and pop. Reset has priority over everything.
- Reset asserted mid-operation: immediate empty state; outputs go to reset values within the same cycle.
- out_ready_i while out_valid_o=0: no effect.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, in_valid_i=1 and no flush, the input pair passes combinationally to the outputs with out_valid_o=1.
  - If out_ready_i=1 the same cycle, the entry is consumed without being written: no pointer or count change.
  - If out_ready_i=0, the entry is written normally.
  - Zero-cycle latency when empty.
- Undefined: minimum latency is 1 cycle as specified above; no combinational path from in_* to out_*.

Decomposition:
- Shared defines file (existing): `RV32_ADDR_WIDTH, `RV32_INST_WIDTH, `INST_NOP, `RST_INST_ADDR, `FLUSH_ENABLE/`FLUSH_DISABLE.
- Add `IF_ID_QUEUE_DEPTH (default 2) to the same file.
- One sub-module: if_id_queue_mem, a DEPTH x (ADDR_WIDTH+INST_WIDTH) register array.
  - One synchronous write port.
  - One asynchronous read port.
  - No reset.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset then idle: outputs after rst_n release are out_valid_o=0, inst_o=0x00000013, inst_addr_o=RST_ADDR, count_o=0, in_ready_o=1.
- Fill without pop, out_ready_i=0, DEPTH=2:
  - Push addr 0x1000/inst 0x00500093, then 0x1004/0x00108113.
  - Required: count_o=2, in_ready_o=0, head shows 0x1000/0x00500093; a third push is not accepted.
- Streaming with out_ready_i=1:
  - Push 8 sequential addresses 0x2000..0x201C, one per cycle.
  - Required: out_valid_o continuously 1 from cycle 1, addresses emerge in order with 1-cycle latency, count_o stays at 1, pointers wrap cleanly.
- Flush with 2 entries held, simultaneous push asserted:
  - Required: flush cycle shows out_valid_o=0 and inst_o=NOP.
  - Next cycle count_o=0; the pushed entry is discarded.
  - A push after flush deasserts emerges as the next head.
- Decoder stall mid-stream:
  - out_ready_i toggles 1,0,0,1 while 4 entries are pushed.
  - Required: no loss or duplication; output order equals input order; count_o tracks 0..DEPTH.
- Async reset mid-operation with count_o=2: outputs go to reset values before the next edge. With IF_ID_QUEUE_BYPASS_EN, an empty queue plus a push gives same-cycle out_valid_o=1 with the pushed data.
